mem_stage: RTL and testbench

- Memory stage of the 5-stage RV64 pipeline.
- Consumes execute_data_t from the execute stage and drives the data bus for LD/SD.
- Produces memory_data_t for writeback.
- Provides an upstream ready/valid stall and a downstream ready/valid handshake, and holds bus requests stable until the bus completes them.

---
 rtl/mem_stage_if.sv | 72 +++++++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Shared pipeline record types and the three handshake interfaces of the memory stage:
// execute->memory, memory->writeback and the data bus.
package mem_stage_pkg;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [63:0] result_alu;
    logic [63:0] wd;
    logic [4:0]  wa;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [63:0] result;
    logic [63:0] wd;
    logic [4:0]  wa;
  } memory_data_t;

endpackage

interface exe_mem_if;
  import mem_stage_pkg::*;

  logic          valid;
  logic          ready;
  execute_data_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface mem_wb_if;
  import mem_stage_pkg::*;

  logic         valid;
  logic         ready;
  memory_data_t data;
  logic         misalign;

  modport master (output valid, output data, output misalign, input ready);
  modport slave  (input valid, input data, input misalign, output ready);
endinterface

interface dbus_if;
  logic        req_valid;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] rdata;

  modport master (
    output req_valid, output addr, output size, output strobe, output wdata,
    input  addr_ok,   input  data_ok, input rdata
  );
  modport slave (
    input  req_valid, input  addr, input size, input strobe, input wdata,
    output addr_ok,   output data_ok, output rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory stage: takes one execute record, performs at most one 8-byte LD/SD on the data bus,
// and holds the writeback record until it is consumed.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  exe_mem_if.slave   in_if,
  mem_wb_if.master   out_if,
  dbus_if.master     dbus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q, state_d;
  logic          kill_q, kill_d;
  execute_data_t req_q;
  memory_data_t  out_q;
  logic          misalign_q;

  logic in_ready;
  logic in_is_mem;
  logic in_misal;
  logic accept;
  logic complete;

  // Address acceptance carries no meaning here; completion is signalled by data_ok alone.
  logic unused_addr_ok;
  assign unused_addr_ok = dbus.addr_ok;

  assign in_is_mem = in_if.data.ctl.memread | in_if.data.ctl.memwrite;
  assign in_misal  = ALIGN_CHECK && in_is_mem && (in_if.data.result_alu[2:0] != 3'b000);
  assign accept    = in_if.valid && in_ready && !flush_i;
  // A killed access still has to drain on the bus, but its result never reaches writeback.
  assign complete  = (state_q == StAccess) && dbus.data_ok && !kill_q && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (accept) begin
          state_d = (in_is_mem && !in_misal) ? StAccess : StDone;
        end else if ((state_q == StDone) && out_if.ready) begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        if (dbus.data_ok) begin
          state_d = (kill_q || flush_i) ? StIdle : StDone;
        end else begin
          kill_d = kill_q || flush_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready       = 1'b0;
    out_if.valid   = 1'b0;
    dbus.req_valid = 1'b0;
    unique case (state_q)
      StIdle:   in_ready = 1'b1;
      StAccess: dbus.req_valid = 1'b1;
      StDone: begin
        in_ready     = out_if.ready;
        out_if.valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q      <= '0;
      out_q      <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      req_q       <= in_if.data;
      misalign_q  <= in_misal;
      out_q.pc    <= in_if.data.pc;
      out_q.ctl   <= in_if.data.ctl;
      out_q.wd    <= in_if.data.wd;
      out_q.wa    <= in_if.data.wa;
      out_q.result <= in_misal ? 64'd0 : in_if.data.result_alu;
      if (in_misal) begin
        out_q.ctl.regwrite <= 1'b0;
      end
    end else if (complete && req_q.ctl.memread) begin
      out_q.result <= dbus.rdata;
    end
  end

  assign in_if.ready     = in_ready;
  assign out_if.data     = out_q;
  assign out_if.misalign = out_if.valid && misalign_q;

  // Bus fields come only from the held request so they stay stable for the whole access.
  assign dbus.addr   = req_q.result_alu;
  assign dbus.size   = 3'b011;
  assign dbus.strobe = req_q.ctl.memwrite ? 8'hff : 8'h00;
  assign dbus.wdata  = req_q.wd;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a bus responder model with programmable latency and a monitor
// that checks each consumed writeback record against expectations queued at issue time.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    memory_data_t d;
    logic         mis;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;

  exe_mem_if in_if();
  mem_wb_if  out_if();
  dbus_if    bus();

  int checks;
  int failures;
  exp_t sb_q[$];

  int          resp_delay;
  logic [63:0] resp_data;
  logic [63:0] exp_addr;
  logic [7:0]  exp_strobe;
  logic [63:0] exp_wdata;
  logic        exp_out_after;
  int          req_count;

  mem_stage #(.ALIGN_CHECK(1'b1)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .in_if   (in_if),
    .out_if  (out_if),
    .dbus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic execute_data_t mk(input logic [63:0] pc, input logic rd, input logic wr,
                                       input logic [63:0] res, input logic [63:0] wd,
                                       input logic [4:0] wa);
    execute_data_t d;
    d                = '0;
    d.pc             = pc;
    d.ctl.alu_op     = 4'h3;
    d.ctl.memtoreg   = rd;
    d.ctl.regwrite   = !wr;
    d.ctl.memread    = rd;
    d.ctl.memwrite   = wr;
    d.result_alu     = res;
    d.wd             = wd;
    d.wa             = wa;
    return d;
  endfunction

  function automatic exp_t model(input execute_data_t d, input logic [63:0] rdata);
    exp_t e;
    logic is_mem;
    is_mem   = d.ctl.memread | d.ctl.memwrite;
    e.d.pc   = d.pc;
    e.d.ctl  = d.ctl;
    e.d.wd   = d.wd;
    e.d.wa   = d.wa;
    e.mis    = is_mem && (d.result_alu[2:0] != 3'b000);
    if (e.mis) begin
      e.d.result       = 64'd0;
      e.d.ctl.regwrite = 1'b0;
    end else begin
      e.d.result = d.ctl.memread ? rdata : d.result_alu;
    end
    return e;
  endfunction

  // Present d until accepted, then check first-cycle behaviour (output or bus request).
  task automatic send(input execute_data_t d, input bit expect_out);
    int   n;
    logic is_mem;
    logic aligned_mem;
    is_mem      = d.ctl.memread | d.ctl.memwrite;
    aligned_mem = is_mem && (d.result_alu[2:0] == 3'b000);
    if (aligned_mem) begin
      exp_addr   = d.result_alu;
      exp_strobe = d.ctl.memwrite ? 8'hff : 8'h00;
      exp_wdata  = d.wd;
    end
    in_if.valid = 1'b1;
    in_if.data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_if.ready && n < 50);
    check_eq("accept", in_if.ready, 1'b1);
    if (expect_out) sb_q.push_back(model(d, resp_data));
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    @(negedge clk);
    if (aligned_mem) check_eq("req_first_cycle", bus.req_valid, 1'b1);
    else             check_eq("out_latency", out_if.valid, 1'b1);
  endtask

  task automatic wait_drain();
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      done = (sb_q.size() == 0) && !out_if.valid && !bus.req_valid;
    end
    check_eq("drain", done, 1'b1);
  endtask

  // Bus responder: data_ok arrives resp_delay cycles after the request rises.
  initial begin
    int   cnt;
    logic ok_prev;
    cnt     = 0;
    ok_prev = 1'b0;
    bus.addr_ok = 1'b0;
    bus.data_ok = 1'b0;
    bus.rdata   = '0;
    forever begin
      @(negedge clk);
      if (ok_prev) begin
        check_eq("out_after_ok", out_if.valid, exp_out_after);
        check_eq("dreq_drop", bus.req_valid, 1'b0);
        ok_prev = 1'b0;
      end
      if (rst_n && bus.req_valid) begin
        if (cnt == 0) req_count++;
        check_eq("dreq_addr", bus.addr, exp_addr);
        check_eq("dreq_strobe", bus.strobe, exp_strobe);
        check_eq("dreq_size", bus.size, 3'b011);
        check_eq("dreq_data", bus.wdata, exp_wdata);
        check_eq("in_ready_access", in_if.ready, 1'b0);
        bus.addr_ok = (cnt == 0);
        if (cnt == resp_delay) begin
          bus.data_ok = 1'b1;
          bus.rdata   = resp_data;
          ok_prev     = 1'b1;
        end else begin
          bus.data_ok = 1'b0;
          bus.rdata   = {$urandom, $urandom};
        end
        cnt++;
      end else begin
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b0;
        cnt = 0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_if.valid && out_if.ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check_eq("out_result", out_if.data.result, e.d.result);
          check_eq("out_pc", out_if.data.pc, e.d.pc);
          check_eq("out_ctl", 64'(out_if.data.ctl), 64'(e.d.ctl));
          check_eq("out_wd", out_if.data.wd, e.d.wd);
          check_eq("out_wa", 64'(out_if.data.wa), 64'(e.d.wa));
          check_eq("out_misalign", out_if.misalign, e.mis);
        end
      end else if (!out_if.valid) begin
        check_eq("misalign_idle", out_if.misalign, 1'b0);
      end
    end
  end

  initial begin
    int r0;
    checks        = 0;
    failures      = 0;
    req_count     = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_if.valid   = 1'b0;
    in_if.data    = '0;
    out_if.ready  = 1'b1;
    resp_delay    = 0;
    resp_data     = '0;
    exp_addr      = '0;
    exp_strobe    = '0;
    exp_wdata     = '0;
    exp_out_after = 1'b1;

    #2;
    check_eq("rst_out_valid", out_if.valid, 1'b0);
    check_eq("rst_dreq_valid", bus.req_valid, 1'b0);
    check_eq("rst_misalign", out_if.misalign, 1'b0);
    check_eq("rst_in_ready", in_if.ready, 1'b1);
    check_eq("rst_result", out_if.data.result, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU op: one cycle, no bus traffic.
    r0 = req_count;
    send(mk(64'h1000, 1'b0, 1'b0, 64'h1234, 64'h0, 5'd5), 1'b1);
    wait_drain();
    check_eq("add_no_req", req_count, r0);

    // Aligned load, three-cycle bus latency.
    resp_delay = 3;
    resp_data  = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    send(mk(64'h1004, 1'b1, 1'b0, 64'h8000_0008, 64'h77, 5'd7), 1'b1);
    wait_drain();
    check_eq("ld_one_req", req_count, r0 + 1);

    // Store completing in the same cycle the request rises.
    resp_delay = 0;
    resp_data  = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    send(mk(64'h1008, 1'b0, 1'b1, 64'h8000_0010, 64'h55, 5'd0), 1'b1);
    wait_drain();
    check_eq("sd_one_req", req_count, r0 + 2);

    // Misaligned load is suppressed.
    @(posedge clk); #1;
    send(mk(64'h100c, 1'b1, 1'b0, 64'h8000_0003, 64'h0, 5'd9), 1'b1);
    wait_drain();
    check_eq("misal_no_req", req_count, r0 + 2);

    // Downstream stall with a queued ADDI taken in the release cycle.
    out_if.ready = 1'b0;
    @(posedge clk); #1;
    send(mk(64'h1010, 1'b0, 1'b0, 64'h1111, 64'h0, 5'd3), 1'b1);
    @(posedge clk); #1;
    fork
      send(mk(64'h1014, 1'b0, 1'b0, 64'h2222, 64'h0, 5'd4), 1'b1);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq("stall_result", out_if.data.result, 64'h1111);
          check_eq("stall_in_ready", in_if.ready, 1'b0);
        end
        @(posedge clk); #1;
        out_if.ready = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", in_if.ready, 1'b1);
      end
    join
    wait_drain();

    // Flush one cycle before data_ok: request drains, nothing is written back.
    resp_delay    = 3;
    resp_data     = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_out_after = 1'b0;
    r0 = req_count;
    @(posedge clk); #1;
    send(mk(64'h1018, 1'b1, 1'b0, 64'h8000_0020, 64'h0, 5'd6), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("flush_out_valid", out_if.valid, 1'b0);
    check_eq("flush_idle", in_if.ready, 1'b1);
    check_eq("flush_one_req", req_count, r0 + 1);
    exp_out_after = 1'b1;

    // Reset in the middle of an access abandons it at once.
    resp_delay = 10;
    @(posedge clk); #1;
    send(mk(64'h101c, 1'b1, 1'b0, 64'h8000_0028, 64'h0, 5'd8), 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_dreq", bus.req_valid, 1'b0);
    check_eq("midrst_out", out_if.valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    resp_delay = 0;
    repeat (6) @(negedge clk);
    check_eq("postrst_out", out_if.valid, 1'b0);
    check_eq("postrst_dreq", bus.req_valid, 1'b0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
